// File: rtl/timer_arbiter_if.sv
// Bundle of the timer_arbiter request/grant signals.
// master: the requester side (drives run/req/len); slave: the arbiter itself.
interface timer_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned CNT_W = 4
);
   logic                   run;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*CNT_W-1:0] len;
   logic [N_REQ-1:0]       grant;
   logic                   en;
   logic [CNT_W-1:0]       cnt;
   logic [N_REQ-1:0]       done;
   logic                   busy;

   modport master (
      output run, req, len,
      input  grant, en, cnt, done, busy
   );

   modport slave (
      input  run, req, len,
      output grant, en, cnt, done, busy
   );
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one timed-enable counter among N_REQ requesters.
// Each grant holds en high for the owner's latched length, then pulses done.
// Build option: define TIMER_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) and no pointer register is built.
module timer_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned CNT_W = 4
) (
   input logic            clk,
   input logic            rst_n,
   timer_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCount = 2'd1,
      StGap   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   len_q, len_d;   // window length latched at grant
   logic [IDX_W-1:0]   owner_q, owner_d;

   logic [IDX_W-1:0]   win;
   logic [CNT_W-1:0]   win_len;

`ifdef TIMER_ARB_RR_EN
   logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

   // Winner search: first requester at or after the pointer (RR) or from index 0.
   always_comb begin
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef TIMER_ARB_RR_EN
         idx = (32'(ptr_q) + i) % N_REQ;
`else
         idx = i;
`endif
         if (!found && bus.req[idx]) begin
            win   = IDX_W'(idx);
            found = 1'b1;
         end
      end
      win_len = bus.len[32'(win)*CNT_W +: CNT_W];
   end

   // Next-state and output logic; run=0 holds everything except done.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      en_d    = en_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      owner_d = owner_q;
      done_d  = '0;
`ifdef TIMER_ARB_RR_EN
      ptr_d   = ptr_q;
`endif
      if (bus.run) begin
         unique case (state_q)
            StIdle: begin
               if (|bus.req) begin
                  owner_d      = win;
                  len_d        = win_len;
                  grant_d      = '0;
                  grant_d[win] = 1'b1;
                  cnt_d        = '0;
`ifdef TIMER_ARB_RR_EN
                  ptr_d = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
`endif
                  if (win_len != '0) begin
                     en_d    = 1'b1;
                     state_d = StCount;
                  end else begin
                     // Zero-length window: complete at once, grant cleared in GAP.
                     done_d[win] = 1'b1;
                     state_d     = StGap;
                  end
               end
            end
            StCount: begin
               if (cnt_q == len_q - 1'b1) begin
                  cnt_d           = '0;
                  en_d            = 1'b0;
                  grant_d         = '0;
                  done_d[owner_q] = 1'b1;
                  state_d         = StGap;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StGap: begin
               grant_d = '0;
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
      busy_d = (state_d != StIdle);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         done_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         owner_q <= owner_d;
      end
   end

`ifdef TIMER_ARB_RR_EN
   // Round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.en    = en_q;
   assign bus.busy  = busy_q;
   assign bus.cnt   = cnt_q;

endmodule
